// File: rtl/sram_responder_if.sv
// Arbiter-side request/response bus of the SRAM responder.
interface sram_responder_if;
  logic        write_to_mem;
  logic        read_to_mem;
  logic [31:0] adr_to_mem;
  logic [31:0] data_to_mem;
  logic [3:0]  sel_to_mem;
  logic [31:0] data_from_mem;
  logic        mem_busy;

  modport master (
    output write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem,
    input  data_from_mem, mem_busy
  );

  modport slave (
    input  write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem,
    output data_from_mem, mem_busy
  );
endinterface

// File: rtl/sram_responder.sv
// Executes one 32-bit bus request as two 16-bit phases on an async SRAM.
// WAIT_CYCLES must lie in 2..15 so every phase has a distinct hold cycle.
module sram_responder #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              nRst,
  sram_responder_if.slave   bus,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);
  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam int unsigned     CntW    = 4;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-2:0] adr_q, adr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        sel_q, sel_d;
  logic              write_q, write_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] sram_adr_q, sram_adr_d;
  logic [15:0]       dq_out_q, dq_out_d;

  logic req, phase, last;
  logic unused_adr;

  assign req        = bus.read_to_mem | bus.write_to_mem;
  assign phase      = (state_q == StLo) | (state_q == StHi);
  assign last       = phase & (cnt_q == CntLast);
  assign unused_adr = ^{bus.adr_to_mem[31:ADDR_W+1], bus.adr_to_mem[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    sram_adr_d = sram_adr_q;
    dq_out_d   = dq_out_q;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          adr_d   = bus.adr_to_mem[ADDR_W:2];
          data_d  = bus.data_to_mem;
          sel_d   = bus.sel_to_mem;
          write_d = bus.write_to_mem;
          cnt_d   = '0;
          if (!bus.write_to_mem || bus.sel_to_mem[1:0] != 2'b00) begin
            state_d = StLo;
          end else if (bus.sel_to_mem[3:2] != 2'b00) begin
            state_d = StHi;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLo: begin
        if (last) begin
          cnt_d = '0;
          if (!write_q) rdata_d[15:0] = sram_dq_in;
          state_d = (!write_q || sel_q[3:2] != 2'b00) ? StHi : StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHi: begin
        if (last) begin
          cnt_d = '0;
          if (!write_q) rdata_d[31:16] = sram_dq_in;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Address/data are registered on phase entry so they stay stable for the whole phase.
    if (state_d == StLo || state_d == StHi) begin
      sram_adr_d = {adr_d, state_d == StHi};
      if (write_d) dq_out_d = (state_d == StHi) ? data_d[31:16] : data_d[15:0];
    end

    if (phase) begin
      sram_ce_n = 1'b0;
      if (write_q) begin
        sram_dq_oe = 1'b1;
        sram_we_n  = last;
        if (state_q == StLo) begin
          sram_lb_n = ~sel_q[0];
          sram_ub_n = ~sel_q[1];
        end else begin
          sram_lb_n = ~sel_q[2];
          sram_ub_n = ~sel_q[3];
        end
      end else begin
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      adr_q      <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      sram_adr_q <= '0;
      dq_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      sram_adr_q <= sram_adr_d;
      dq_out_q   <= dq_out_d;
    end
  end

  assign bus.mem_busy      = phase | ((state_q == StIdle) & req);
  assign bus.data_from_mem = rdata_q;
  assign sram_adr          = sram_adr_q;
  assign sram_dq_out       = dq_out_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: cycle traces, a vector table on a W=2 instance and
// reset / back-to-back sequences, with a W=3 instance for the latter.
module tb_sram_responder;
  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  sram_responder_if bus2 ();
  sram_responder_if bus3 ();

  logic [17:0] adr2, adr3;
  logic [15:0] dqo2, dqo3, dqi2, dqi3;
  logic dqoe2, dqoe3, ce2, ce3, oen2, oen3, we2, we3, ub2, ub3, lb2, lb3;

  sram_responder #(.ADDR_W(18), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .nRst(nRst), .bus(bus2), .sram_adr(adr2), .sram_dq_out(dqo2),
    .sram_dq_in(dqi2), .sram_dq_oe(dqoe2), .sram_ce_n(ce2), .sram_oe_n(oen2),
    .sram_we_n(we2), .sram_ub_n(ub2), .sram_lb_n(lb2)
  );

  sram_responder #(.ADDR_W(18), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .nRst(nRst), .bus(bus3), .sram_adr(adr3), .sram_dq_out(dqo3),
    .sram_dq_in(dqi3), .sram_dq_oe(dqoe3), .sram_ce_n(ce3), .sram_oe_n(oen3),
    .sram_we_n(we3), .sram_ub_n(ub3), .sram_lb_n(lb3)
  );

  // SRAM models: 256 halfwords each, byte-lane writes while ce_n/we_n are low.
  logic [15:0] mem2 [256];
  logic [15:0] mem3 [256];
  logic        pre_we, pre_sel;
  logic [7:0]  pre_a;
  logic [15:0] pre_d;

  assign dqi2 = mem2[adr2[7:0]];
  assign dqi3 = mem3[adr3[7:0]];

  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem2[pre_a] <= pre_d;
    else if (!ce2 && !we2) begin
      if (!lb2) mem2[adr2[7:0]][7:0]  <= dqo2[7:0];
      if (!ub2) mem2[adr2[7:0]][15:8] <= dqo2[15:8];
    end
  end

  always @(posedge clk) begin
    if (pre_we && pre_sel) mem3[pre_a] <= pre_d;
    else if (!ce3 && !we3) begin
      if (!lb3) mem3[adr3[7:0]][7:0]  <= dqo3[7:0];
      if (!ub3) mem3[adr3[7:0]][15:8] <= dqo3[15:8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic sel3, input logic [7:0] a, input logic [15:0] d);
    pre_sel = sel3;
    pre_a   = a;
    pre_d   = d;
    pre_we  = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // {busy, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe, 0, adr[7:0], dq_out}
  function automatic logic [31:0] snap2();
    return {bus2.mem_busy, ce2, oen2, we2, lb2, ub2, dqoe2, 1'b0, adr2[7:0], dqo2};
  endfunction

  task automatic drive2(input logic rd, input logic wr, input logic [31:0] adr,
                        input logic [31:0] data, input logic [3:0] sel);
    bus2.read_to_mem  = rd;
    bus2.write_to_mem = wr;
    bus2.adr_to_mem   = adr;
    bus2.data_to_mem  = data;
    bus2.sel_to_mem   = sel;
  endtask

  logic [31:0] tr_exp [6];

  task automatic run_trace(input string name, input logic rd, input logic wr,
                           input logic [31:0] adr, input logic [31:0] data,
                           input logic [3:0] sel);
    @(posedge clk);
    #1 drive2(rd, wr, adr, data, sel);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), snap2(), tr_exp[c]);
      if (!bus2.mem_busy || c == 5) begin
        bus2.read_to_mem  = 1'b0;
        bus2.write_to_mem = 1'b0;
      end
    end
  endtask

  // Returns at the negedge of the first cycle with mem_busy low.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] adr,
                         input logic [31:0] data, input logic [3:0] sel,
                         output int done_cyc, output int ce_cyc);
    done_cyc = -1;
    ce_cyc   = 0;
    @(posedge clk);
    #1 drive2(rd, wr, adr, data, sel);
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (!ce2) ce_cyc++;
      if (!bus2.mem_busy) begin
        done_cyc          = c;
        bus2.read_to_mem  = 1'b0;
        bus2.write_to_mem = 1'b0;
      end
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL req timeout: busy still %b after 40 cycles, want 0", bus2.mem_busy);
      bus2.read_to_mem  = 1'b0;
      bus2.write_to_mem = 1'b0;
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          done_cyc;
    int          ce_cyc;
    logic [31:0] dfm;
    logic [31:0] mem;
  } vec_t;

  vec_t        vecs [10];
  logic [24:0] pl [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int          dc, cc;
    logic [7:0]  lo_a, hi_a;
    logic [15:0] busy_seq;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'hF, 5, 4, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h12345678,  4'hF, 5, 4, 32'hDEADBEEF, 32'h12345678};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 5, 4, 32'h12345678, 32'h12345678};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABBCCDD,  4'h4, 3, 2, 32'h12345678, 32'h11BB2222};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0040, 32'hFFFFFFFF,  4'h0, 1, 0, 32'h12345678, 32'h44443333};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0040, 32'h99887766,  4'h1, 3, 2, 32'h12345678, 32'h44443366};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0040, 32'h99887766,  4'h2, 3, 2, 32'h12345678, 32'h44447766};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0060, 32'hA1B2C3D4,  4'h8, 3, 2, 32'h12345678, 32'hA1665555};
    vecs[8] = '{1'b1, 1'b0, 32'hFFF8_0063, 32'h0,         4'hF, 5, 4, 32'hA1665555, 32'hA1665555};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 5, 4, 32'hDEADBEEF, 32'hDEADBEEF};

    pl = '{25'h082BEEF, 25'h083DEAD, 25'h0080000, 25'h0090000, 25'h0102222,
           25'h0111111, 25'h0203333, 25'h0214444, 25'h0305555, 25'h0316666,
           25'h182BEEF, 25'h183DEAD, 25'h1300123, 25'h1314567};

    pre_we = 1'b0; pre_sel = 1'b0; pre_a = '0; pre_d = '0;
    drive2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus3.read_to_mem = 1'b0; bus3.write_to_mem = 1'b0;
    bus3.adr_to_mem = 32'h0; bus3.data_to_mem = 32'h0; bus3.sel_to_mem = 4'h0;
    nRst = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset snap", snap2(), 32'h7C00_0000);
    check("reset dfm", bus2.data_from_mem, 32'h0);
    check("reset w3", {bus3.mem_busy, ce3, we3, dqoe3, bus3.data_from_mem[3:0]}, 8'h60);
    @(posedge clk);
    #1 nRst = 1'b1;

    for (int i = 0; i < 14; i++) preload(pl[i][24], pl[i][23:16], pl[i][15:0]);

    // Full-word read trace, W=2.
    tr_exp = '{32'hFC00_0000, 32'h9082_0000, 32'h9082_0000,
               32'h9083_0000, 32'h9083_0000, 32'h7C83_0000};
    run_trace("rd trace", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
    check("rd trace dfm", bus2.data_from_mem, 32'hDEADBEEF);

    // Full-word write trace.
    tr_exp = '{32'hFC83_0000, 32'hA208_5678, 32'hB208_5678,
               32'hA209_1234, 32'hB209_1234, 32'h7C09_1234};
    run_trace("wr trace", 1'b0, 1'b1, 32'h0000_0010, 32'h12345678, 4'hF);
    check("wr trace dfm", bus2.data_from_mem, 32'hDEADBEEF);
    @(posedge clk);
    #1 check("wr readback", {mem2[9], mem2[8]}, 32'h12345678);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].data, vecs[i].sel, dc, cc);
      check($sformatf("v%0d done", i), dc, vecs[i].done_cyc);
      check($sformatf("v%0d ce cycles", i), cc, vecs[i].ce_cyc);
      check($sformatf("v%0d dfm", i), bus2.data_from_mem, vecs[i].dfm);
      @(posedge clk);
      #1;
      lo_a = {vecs[i].adr[8:2], 1'b0};
      hi_a = {vecs[i].adr[8:2], 1'b1};
      check($sformatf("v%0d mem", i), {mem2[hi_a], mem2[lo_a]}, vecs[i].mem);
    end

    // Reset in the first HI cycle of a write: LO already wrote, HI must not.
    drive2(1'b0, 1'b1, 32'h0000_0010, 32'hCAFEF00D, 4'hF);
    repeat (4) @(negedge clk);
    check("pre-rst hi", {23'h0, adr2[7:0], we2}, {23'h0, 8'h09, 1'b0});
    nRst = 1'b0;
    bus2.write_to_mem = 1'b0;
    #1;
    check("rst mid-hi snap", snap2(), 32'h7C00_0000);
    check("rst mid-hi dfm", bus2.data_from_mem, 32'h0);
    @(posedge clk);
    #1 nRst = 1'b1;
    run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, dc, cc);
    check("post-rst done", dc, 5);
    check("post-rst dfm", bus2.data_from_mem, 32'h1234F00D);

    // Back-to-back reads on W=3 with the request held through DONE.
    @(posedge clk);
    #1;
    bus3.read_to_mem = 1'b1;
    bus3.adr_to_mem  = 32'h0000_0104;
    bus3.sel_to_mem  = 4'hF;
    busy_seq = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      busy_seq[c] = bus3.mem_busy;
      if (c == 1) begin
        check("b2b adr c1", {14'h0, adr3}, 32'h82);
        bus3.adr_to_mem = 32'h0000_0060;
      end
      if (c == 7) check("b2b dfm first", bus3.data_from_mem, 32'hDEADBEEF);
      if (c == 15) begin
        check("b2b dfm second", bus3.data_from_mem, 32'h45670123);
        bus3.read_to_mem = 1'b0;
      end
    end
    check("b2b busy seq", {16'h0, busy_seq}, 32'h7F7F);
    @(posedge clk);
    #1 check("b2b idle", {31'h0, bus3.mem_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
